// File: rtl/serpent_round_ctrl.sv
// Iterative Serpent-128 encryption controller: one shared round datapath run
// ROUNDS times, with external S-box, internal linear transform and subkey RAM.
`timescale 1ns/1ps

module linear_transform (
    input  logic [127:0] x,
    output logic [127:0] y
);

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    logic [31:0] a0, a1, a2, a3;
    logic [31:0] b0, b1, b2, b3;
    logic [31:0] c0, c1, c2, c3;

    always_comb begin
        a0 = rotl(x[31:0], 13);
        a2 = rotl(x[95:64], 3);
        a1 = x[63:32] ^ a0 ^ a2;
        a3 = x[127:96] ^ a2 ^ (a0 << 3);
        b1 = rotl(a1, 1);
        b3 = rotl(a3, 7);
        b0 = a0 ^ b1 ^ b3;
        b2 = a2 ^ b3 ^ (b1 << 7);
        c0 = rotl(b0, 5);
        c2 = rotl(b2, 22);
        c1 = b1;
        c3 = b3;
        y  = {c3, c2, c1, c0};
    end

endmodule

module serpent_round_ctrl #(
    parameter int ROUNDS = 32,
    parameter int AW     = 6
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [127:0]  i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [127:0]  o_data,
    output logic          o_busy,
    output logic [AW-1:0] o_sk_addr,
    input  logic [127:0]  i_sk_data,
    output logic [2:0]    o_sb_sel,
    output logic [127:0]  o_sb_in,
    input  logic [127:0]  i_sb_out,
    output logic [4:0]    o_round,
    output logic [1:0]    o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid/data stay stable until that edge, ready may change freely.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    state_t        state;
    logic [127:0]  x;
    logic [127:0]  lt_out;

    linear_transform u_lt (
        .x (i_sb_out),
        .y (lt_out)
    );

    // The RAM registers its address, so the address driven during round r
    // selects the subkey consumed in round r+1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            x         <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_ready   <= 1'b1;
            o_busy    <= 1'b0;
            o_sk_addr <= '0;
            o_round   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        x         <= i_data;
                        o_round   <= '0;
                        o_sk_addr <= AW'(1);
                        o_ready   <= 1'b0;
                        o_busy    <= 1'b1;
                        state     <= ROUND;
                    end
                end
                ROUND: begin
                    if (o_round == LAST_ROUND) begin
                        // Final round: the linear transform is replaced by
                        // the closing key mix in FINAL.
                        x     <= i_sb_out;
                        state <= FINAL;
                    end else begin
                        x         <= lt_out;
                        o_round   <= o_round + 5'd1;
                        o_sk_addr <= AW'(o_round) + AW'(2);
                    end
                end
                FINAL: begin
                    o_data    <= x ^ i_sk_data;
                    o_valid   <= 1'b1;
                    o_sk_addr <= '0;
                    state     <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_round <= '0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_sb_in     = x ^ i_sk_data;
    assign o_sb_sel    = (state == ROUND) ? o_round[2:0] : 3'd0;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_serpent_round_ctrl.sv
// Directed bench for serpent_round_ctrl with bench-side S-box, subkey RAM and
// reference encryption model.
`timescale 1ns/1ps

module tb_serpent_round_ctrl;

    localparam int ROUNDS = 32;
    localparam int AW     = 6;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [127:0]  i_data;
    logic          o_valid;
    logic          i_ready;
    logic [127:0]  o_data;
    logic          o_busy;
    logic [AW-1:0] sk_addr;
    logic [127:0]  sk_data;
    logic [2:0]    sb_sel;
    logic [127:0]  sb_in;
    logic [127:0]  sb_out;
    logic [4:0]    round;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] ram [64];

    serpent_round_ctrl #(.ROUNDS(ROUNDS), .AW(AW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_busy      (o_busy),
        .o_sk_addr   (sk_addr),
        .i_sk_data   (sk_data),
        .o_sb_sel    (sb_sel),
        .o_sb_in     (sb_in),
        .i_sb_out    (sb_out),
        .o_round     (round),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference functions ----------------
    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] sbox_slice(input logic [2:0] sel, input logic [127:0] v);
        logic [63:0]  tbl;
        logic [3:0]   nib;
        logic [3:0]   o;
        logic [127:0] y;
        case (sel)
            3'd0: tbl = 64'hC90724DEB56A1F83;
            3'd1: tbl = 64'h43D68EB1A50972CF;
            3'd2: tbl = 64'h25B04E1DFAC39768;
            3'd3: tbl = 64'hE57A421D369C8BF0;
            3'd4: tbl = 64'hD7E9A4526B0C38F1;
            3'd5: tbl = 64'h176D8E30C9A4B25F;
            3'd6: tbl = 64'h0A3DF19EB6485C27;
            default: tbl = 64'h6539AC47B28E0FD1;
        endcase
        y = '0;
        for (int j = 0; j < 32; j++) begin
            nib = {v[96+j], v[64+j], v[32+j], v[j]};
            o   = 4'((tbl >> (4 * int'(nib))) & 64'hF);
            y[j]    = o[0];
            y[32+j] = o[1];
            y[64+j] = o[2];
            y[96+j] = o[3];
        end
        return y;
    endfunction

    function automatic logic [127:0] lt_model(input logic [127:0] v);
        logic [31:0] w0, w1, w2, w3;
        w0 = v[31:0]; w1 = v[63:32]; w2 = v[95:64]; w3 = v[127:96];
        w0 = rotl(w0, 13);
        w2 = rotl(w2, 3);
        w1 = w1 ^ w0 ^ w2;
        w3 = w3 ^ w2 ^ (w0 << 3);
        w1 = rotl(w1, 1);
        w3 = rotl(w3, 7);
        w0 = w0 ^ w1 ^ w3;
        w2 = w2 ^ w3 ^ (w1 << 7);
        w0 = rotl(w0, 5);
        w2 = rotl(w2, 22);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [127:0] encrypt_model(input logic [127:0] pt);
        logic [127:0] s;
        s = pt;
        for (int r = 0; r < ROUNDS; r++) begin
            s = sbox_slice(3'(r % 8), s ^ ram[r]);
            if (r < ROUNDS - 1) s = lt_model(s);
        end
        return s ^ ram[ROUNDS];
    endfunction

    // ---------------- external models: S-box and subkey RAM ----------------
    always_comb sb_out = sbox_slice(sb_sel, sb_in);

    always_ff @(posedge clk) sk_data <= ram[sk_addr];

    task automatic load_ram_counting();
        for (int n = 0; n < 64; n++) ram[n] = {4{32'(n)}};
    endtask

    task automatic load_ram_zero_key();
        logic [31:0] w [140];
        for (int i = 0; i < 8; i++) w[i] = 32'd0;
        w[4] = 32'd1;
        for (int i = 0; i < 132; i++)
            w[i+8] = rotl(w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9e3779b9 ^ 32'(i), 11);
        for (int n = 0; n < 64; n++) ram[n] = '0;
        for (int k = 0; k <= ROUNDS; k++)
            ram[k] = sbox_slice(3'((35 - k) % 8), {w[4*k+11], w[4*k+10], w[4*k+9], w[4*k+8]});
    endtask

    // ---------------- drivers ----------------
    task automatic send_block(input logic [127:0] pt);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = pt;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data  = '0;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (o_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_checks++; if (sk_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", sk_addr); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_checks++; if (o_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_data); end
        n_checks++; if (round !== 5'd0) begin n_fail++; $display("FAIL reset_round: got %0d want 0", round); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_single_block();
        logic [127:0] pt;
        logic [127:0] exp_ct;
        int           exp_addr;
        load_ram_counting();
        pt     = 128'h0123456789abcdeffedcba9876543210;
        exp_ct = encrypt_model(pt);
        i_ready = 1'b1;
        send_block(pt);
        n_checks++; if (sk_addr !== AW'(1)) begin n_fail++; $display("FAIL accept_addr: got %0d want 1", sk_addr); end
        n_checks++; if (round !== 5'd0) begin n_fail++; $display("FAIL accept_round: got %0d want 0", round); end
        n_checks++; if (sb_sel !== 3'd0) begin n_fail++; $display("FAIL accept_sel: got %0d want 0", sb_sel); end
        n_checks++; if (o_ready !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL accept_flags: ready %b busy %b want 0 1", o_ready, o_busy); end
        for (int e = 1; e <= 33; e++) begin
            @(posedge clk);
            #1;
            exp_addr = (e <= 31) ? e + 1 : ((e == 32) ? 32 : 0);
            n_checks++;
            if (sk_addr !== AW'(exp_addr)) begin n_fail++; $display("FAIL addr_seq edge %0d: got %0d want %0d", e, sk_addr, exp_addr); end
            if (e <= 31) begin
                n_checks++;
                if (round !== 5'(e)) begin n_fail++; $display("FAIL round_seq edge %0d: got %0d want %0d", e, round, e); end
                n_checks++;
                if (sb_sel !== 3'(e % 8)) begin n_fail++; $display("FAIL sel_seq edge %0d: got %0d want %0d", e, sb_sel, e % 8); end
            end
            if (e == 32) begin
                n_checks++;
                if (round !== 5'd31) begin n_fail++; $display("FAIL round_final: got %0d want 31", round); end
            end
            if (e < 33) begin
                n_checks++;
                if (o_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid edge %0d: got %b want 0", e, o_valid); end
            end else begin
                n_checks++;
                if (o_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b want 1", o_valid); end
                n_checks++;
                if (o_data !== exp_ct) begin n_fail++; $display("FAIL single_ct: got %h want %h", o_data, exp_ct); end
            end
        end
        @(posedge clk);
        #1;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL single_release_valid: got %b want 0", o_valid); end
        n_checks++; if (o_ready !== 1'b1 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL single_release_idle: ready %b state %0d want 1 0", o_ready, dbg_state); end
        n_checks++; if (round !== 5'd0) begin n_fail++; $display("FAIL single_round_wrap: got %0d want 0", round); end
    endtask

    task automatic test_kat();
        logic [127:0] exp_ct;
        bit           seen;
        load_ram_zero_key();
        exp_ct  = encrypt_model('0);
        i_ready = 1'b1;
        send_block('0);
        wait_valid(40, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL kat_timeout: got no o_valid want o_valid within 40 cycles"); end
        n_checks++; if (o_data !== exp_ct) begin n_fail++; $display("FAIL kat_ct: got %h want %h", o_data, exp_ct); end
        n_checks++; if (o_data[31:0] !== exp_ct[31:0]) begin n_fail++; $display("FAIL kat_word0: got %h want %h", o_data[31:0], exp_ct[31:0]); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [127:0] pt;
        logic [127:0] exp_ct;
        bit           seen;
        load_ram_counting();
        pt      = 128'hdeadbeef_00112233_44556677_8899aabb;
        exp_ct  = encrypt_model(pt);
        i_ready = 1'b0;
        send_block(pt);
        wait_valid(40, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_timeout: got no o_valid want o_valid within 40 cycles"); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 3) begin
                i_valid = 1'b1;
                i_data  = ~pt;
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== exp_ct) begin n_fail++; $display("FAIL bp_hold cycle %0d: valid %b data %h want 1 %h", c, o_valid, o_data, exp_ct); end
            n_checks++;
            if (o_ready !== 1'b0 || dbg_state !== 2'd3) begin n_fail++; $display("FAIL bp_state cycle %0d: ready %b state %0d want 0 3", c, o_ready, dbg_state); end
        end
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", o_valid); end
        n_checks++; if (dbg_state !== 2'd0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_idle: state %0d ready %b want 0 1", dbg_state, o_ready); end
        @(posedge clk);
        #1;
        n_checks++; if (o_busy !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL bp_no_accept: busy %b state %0d want 0 0", o_busy, dbg_state); end
    endtask

    task automatic test_reset_mid();
        bit found;
        load_ram_counting();
        i_ready = 1'b1;
        send_block(128'h11111111_22222222_33333333_44444444);
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (round == 5'd15) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL mid_round_timeout: got round %0d want 15", round); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags: valid %b busy %b want 0 0", o_valid, o_busy); end
        n_checks++; if (sk_addr !== '0 || round !== 5'd0) begin n_fail++; $display("FAIL mid_reset_regs: addr %0d round %0d want 0 0", sk_addr, round); end
        n_checks++; if (o_ready !== 1'b1 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL mid_reset_idle: ready %b state %0d want 1 0", o_ready, dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [3];
        logic [127:0] exp_q [$];
        logic [127:0] exp_ct;
        bit           seen;
        load_ram_counting();
        pts[0] = 128'hcafef00d_0badc0de_12345678_9abcdef0;
        pts[1] = 128'h00000000_00000000_00000000_00000001;
        pts[2] = {4{32'hffffffff}};
        i_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            exp_q.push_back(encrypt_model(pts[b]));
            send_block(pts[b]);
            wait_valid(40, seen);
            exp_ct = exp_q.pop_front();
            n_checks++;
            if (!seen) begin n_fail++; $display("FAIL b2b_timeout block %0d: got no o_valid want o_valid", b); end
            n_checks++;
            if (o_data !== exp_ct) begin n_fail++; $display("FAIL b2b_ct block %0d: got %h want %h", b, o_data, exp_ct); end
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b1;
        load_ram_counting();
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_block();
        test_kat();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
